float_mac_arbiter: RTL and testbench
====================================

Name: float_mac_arbiter

Overview:
- Shares one pipelined FloatMultiplyAddWithFloat datapath among NUM_REQ independent dot-product requesters.
- Each requester streams (a, b, last) operand pairs.
- The block keeps a per-requester accumulator, issues one element per cycle round-robin, and tracks in-flight results with a tag pipeline.
- When a stream's last element returns, the block presents the final sum on that requester's result port.
- It sits between the operand-fetch logic of the dot-product engine and the FMA instance, which is instantiated outside this block.

Parameters:
NUM_REQ, 4, number of requesters
EXP_IN, 3, exponent bits of a/b operands
FRAC_IN, 2, fraction bits of a/b operands
EXP_OUT, 5, exponent bits of accumulator
FRAC_OUT, 8, fraction bits of accumulator
FMA_LATENCY, 2, cycles from FMA input registers to valid fma_acc_out (at least 1)

Ports:
clock  in  1  single clock
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  operand pair valid, one bit per requester
req_ready  out  NUM_REQ  grant/accept, one bit per requester
req_a  in  NUM_REQ*IN_W  packed {sign,exp,frac}; IN_W=1+EXP_IN+FRAC_IN
req_b  in  NUM_REQ*IN_W  packed b operands
req_last  in  NUM_REQ  marks final element of a stream
res_valid  out  NUM_REQ  final sum available
res_ready  in  NUM_REQ  consumer accepts sum
res_data  out  NUM_REQ*OUT_W  per-requester sum; OUT_W=1+EXP_OUT+FRAC_OUT
fma_a  out  IN_W  registered FMA operand a
fma_b  out  IN_W  registered FMA operand b
fma_acc_in  out  OUT_W  registered FMA accumulator input
fma_acc_out  in  OUT_W  FMA result
idle  out  1  no request pending, no tag in flight, no result held

Behaviour:
- Reset (async, active-high):
  - all accumulators 0 (+0.0); first=1, busy=0, done=0 for every requester.
  - tag pipe cleared, round-robin pointer to 0.
  - fma_a/b/acc_in = 0, req_ready = 0, res_valid = 0, idle = 1.
- Reset mid-operation discards every in-flight tag. A late fma_acc_out value is never written back.
- Eligibility: requester i is eligible when req_valid[i] & ~busy[i] & ~done[i].
- Arbitration: combinational round-robin grant. Search starts at (last granted + 1) mod NUM_REQ; at most one grant per cycle.
- Handshake: req_ready[i] = grant[i], so ready depends on valid. Requesters must not make valid depend on ready. A transfer occurs when req_valid & req_ready.
- Issue at cycle t, for granted requester i:
  - fma_a, fma_b register req_a[i], req_b[i].
  - fma_acc_in registers +0.0 if first[i], else acc[i].
  - set busy[i] and clear first[i].
  - push tag {valid=1, id=i, last=req_last[i]} into a tag shift register of depth 1+FMA_LATENCY.
  - With no grant, fma_* hold their previous values and a tag with valid=0 is pushed.
- Writeback at cycle t+1+FMA_LATENCY:
  - tag valid: acc[id] <= fma_acc_out; busy[id] <= 0.
  - if tag.last: done[id] <= 1 and first[id] <= 1.
- Per-requester throughput is one element per 2+FMA_LATENCY cycles. NUM_REQ >= 2+FMA_LATENCY saturates the FMA.
- Result port: res_valid[i] = done[i]; res_data[i] = acc[i].
  - On res_valid[i] & res_ready[i], done[i] clears next cycle.
  - While done[i] is set, requester i is not eligible (backpressure).
- Simultaneous events:
  - A writeback and an issue never target the same requester in one cycle, because busy blocks issue.
  - Result accept and a new grant for the same requester cannot coincide; eligibility resumes the cycle after done clears.
- A single-element stream (last on first element) yields a*b + 0.
- idle = ~|req_valid & ~|busy & ~|done & no valid tag.

Decomposition:
- Package float_mac_pkg holds:
  - the tag struct {valid, id[$clog2(NUM_REQ)], last}
  - the FLOAT_ZERO constant
  - the IN_W/OUT_W width functions
- One sub-module, rr_arbiter (NUM_REQ-wide, pointer-based round-robin, one-hot grant), is reused by the dot-product engine.

Test Plan:
- Single requester, pairs (1.0,2.0),(1.5,2.0,last), behavioural FMA with FMA_LATENCY=2 -> req_ready pulses 4 cycles apart; res_valid[0] with res_data = 5.0; next stream starts from +0.0.
- All four requesters valid continuously, 3-element streams of (1.0,1.0) -> grants 0,1,2,3,0,...; one issue every cycle; each res_data = 3.0.
- res_ready[2] held low for 10 cycles after requester 2 finishes -> req_ready[2] stays 0; other requesters keep issuing; 2 resumes the cycle after acceptance.
- Single-element stream (-2.0,0.5,last) on requester 3 -> res_data[3] = -1.0; fma_acc_in observed = +0.0 at issue.
- Assert reset with 3 tags in flight -> all outputs reset values; no writeback after release; first post-reset stream sum is correct.
- Requesters 1 and 3 only, valid toggling randomly -> no grant to a busy requester (assertion); sums match reference model; idle = 1 after drain.

Source files
------------

// File: rtl/float_mac_pkg.sv
// float_mac_pkg: shared types and helpers for the float_mac_arbiter slice.
//   tag_t      - in-flight tag carried alongside each FMA issue
//   FLOAT_ZERO - +0.0 encoding; slice to the width in use
//   in_w/out_w - packed float widths {sign,exp,frac}
//   idx_w      - index width for an N-entry one-hot set
package float_mac_pkg;

  // Wide enough for up to 256 requesters; users compare against the full field.
  localparam int unsigned TAG_ID_W = 8;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
    logic                last;
  } tag_t;

  localparam logic [63:0] FLOAT_ZERO = '0;

  function automatic int unsigned in_w(input int unsigned exp_bits, input int unsigned frac_bits);
    return 1 + exp_bits + frac_bits;
  endfunction

  function automatic int unsigned out_w(input int unsigned exp_bits, input int unsigned frac_bits);
    return 1 + exp_bits + frac_bits;
  endfunction

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/float_mac_arbiter_if.sv
// float_mac_arbiter_if: requester-side operand and result handshakes.
//   req_valid/req_ready/req_a/req_b/req_last - per-requester operand stream
//   res_valid/res_ready/res_data             - per-requester final sum
//   master: requester/consumer side, slave: float_mac_arbiter side
interface float_mac_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IN_W    = 6,
  parameter int unsigned OUT_W   = 14
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*IN_W-1:0]  req_a;
  logic [NUM_REQ*IN_W-1:0]  req_b;
  logic [NUM_REQ-1:0]       req_last;
  logic [NUM_REQ-1:0]       res_valid;
  logic [NUM_REQ-1:0]       res_ready;
  logic [NUM_REQ*OUT_W-1:0] res_data;

  modport master (
    output req_valid, req_a, req_b, req_last, res_ready,
    input  req_ready, res_valid, res_data
  );

  modport slave (
    input  req_valid, req_a, req_b, req_last, res_ready,
    output req_ready, res_valid, res_data
  );
endinterface

// File: rtl/float_mac_arbiter_rr_arbiter.sv
// rr_arbiter: pointer-based round-robin arbiter with one-hot grant.
//   clock, reset - clock and async active-high reset (pointer -> 0)
//   req          - request vector
//   grant        - one-hot grant (combinational)
//   grant_idx    - index of the granted request
//   any_grant    - a grant is being issued this cycle
// The pointer holds the first index searched; it moves to grant_idx+1 after
// every grant, since every grant is assumed accepted in the same cycle.
module rr_arbiter
  import float_mac_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  output logic [NUM_REQ-1:0]          grant,
  output logic [idx_w(NUM_REQ)-1:0]   grant_idx,
  output logic                        any_grant
);
  localparam int unsigned IDX_W = idx_w(NUM_REQ);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    sum       = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      // (ptr + k) mod NUM_REQ without a divider
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      cand = sum[IDX_W-1:0];
      if (!any_grant && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        any_grant   = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (any_grant) begin
      ptr <= (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
    end
  end
endmodule

// File: rtl/float_mac_arbiter.sv
// float_mac_arbiter: shares one external pipelined FMA among NUM_REQ
// dot-product requesters, keeping a per-requester accumulator.
//   clock, reset - clock and async active-high reset
//   bus          - slave side of float_mac_arbiter_if (operands in, sums out)
//   fma_a/fma_b  - registered FMA multiplicands
//   fma_acc_in   - registered FMA addend (+0.0 on the first element of a stream)
//   fma_acc_out  - FMA result, valid FMA_LATENCY cycles after the input registers
//   idle         - nothing requested, nothing in flight, no result held
module float_mac_arbiter
  import float_mac_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned EXP_IN      = 3,
  parameter int unsigned FRAC_IN     = 2,
  parameter int unsigned EXP_OUT     = 5,
  parameter int unsigned FRAC_OUT    = 8,
  parameter int unsigned FMA_LATENCY = 2
) (
  input  logic                                clock,
  input  logic                                reset,
  float_mac_arbiter_if.slave                  bus,
  output logic [in_w(EXP_IN, FRAC_IN)-1:0]    fma_a,
  output logic [in_w(EXP_IN, FRAC_IN)-1:0]    fma_b,
  output logic [out_w(EXP_OUT, FRAC_OUT)-1:0] fma_acc_in,
  input  logic [out_w(EXP_OUT, FRAC_OUT)-1:0] fma_acc_out,
  output logic                                idle
);
  localparam int unsigned IN_W  = in_w(EXP_IN, FRAC_IN);
  localparam int unsigned OUT_W = out_w(EXP_OUT, FRAC_OUT);
  localparam int unsigned IDX_W = idx_w(NUM_REQ);
  localparam int unsigned DEPTH = 1 + FMA_LATENCY;

  logic [OUT_W-1:0]   acc [NUM_REQ];
  logic [NUM_REQ-1:0] first, busy, done;
  logic [NUM_REQ-1:0] elig, grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               any_grant;

  logic [IN_W-1:0]    sel_a, sel_b;
  logic [OUT_W-1:0]   sel_acc;
  logic               sel_last;

  tag_t               tag_pipe [DEPTH];
  tag_t               issue_tag, wb_tag;
  logic               tags_live;

  // Gated by reset so req_ready is 0 while reset is held.
  always_comb elig = bus.req_valid & ~busy & ~done & {NUM_REQ{~reset}};

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clock     (clock),
    .reset     (reset),
    .req       (elig),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  always_comb bus.req_ready = grant;

  // Operand mux driven by the one-hot grant.
  always_comb begin
    sel_a    = '0;
    sel_b    = '0;
    sel_acc  = '0;
    sel_last = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_a    = bus.req_a[i*IN_W +: IN_W];
        sel_b    = bus.req_b[i*IN_W +: IN_W];
        sel_acc  = first[i] ? FLOAT_ZERO[OUT_W-1:0] : acc[i];
        sel_last = bus.req_last[i];
      end
    end
  end

  always_comb begin
    issue_tag       = '0;
    issue_tag.valid = any_grant;
    issue_tag.id    = TAG_ID_W'(grant_idx);
    issue_tag.last  = any_grant & sel_last;
    wb_tag          = tag_pipe[DEPTH-1];
    tags_live       = 1'b0;
    for (int unsigned k = 0; k < DEPTH; k++) tags_live = tags_live | tag_pipe[k].valid;
  end

  always_comb begin
    bus.res_valid = done;
    bus.res_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) bus.res_data[i*OUT_W +: OUT_W] = acc[i];
  end

  always_comb idle = ~|bus.req_valid & ~|busy & ~|done & ~tags_live;

  // Stage DEPTH-1 lines up with fma_acc_out for the element issued
  // 1+FMA_LATENCY cycles earlier.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < DEPTH; k++) tag_pipe[k] <= '0;
    end else begin
      tag_pipe[0] <= issue_tag;
      for (int unsigned k = 1; k < DEPTH; k++) tag_pipe[k] <= tag_pipe[k-1];
    end
  end

  // Issue and writeback never hit the same requester in a cycle (busy blocks
  // issue), so their per-requester updates do not overlap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      first      <= '1;
      busy       <= '0;
      done       <= '0;
      fma_a      <= '0;
      fma_b      <= '0;
      fma_acc_in <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) acc[i] <= '0;
    end else begin
      if (any_grant) begin
        fma_a      <= sel_a;
        fma_b      <= sel_b;
        fma_acc_in <= sel_acc;
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (done[i] && bus.res_ready[i]) done[i] <= 1'b0;
        if (grant[i]) begin
          busy[i]  <= 1'b1;
          first[i] <= 1'b0;
        end
        if (wb_tag.valid && (wb_tag.id == TAG_ID_W'(i))) begin
          acc[i]  <= fma_acc_out;
          busy[i] <= 1'b0;
          if (wb_tag.last) begin
            done[i]  <= 1'b1;
            first[i] <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_float_mac_arbiter.sv
module tb_float_mac_arbiter;
  localparam int N = 4, EI = 3, FI = 2, EO = 5, FO = 8, LAT = 2;
  localparam int IW = 1 + EI + FI, OW = 1 + EO + FO, BO = 15;

  localparam logic [IW-1:0] F1_0 = 6'b001100, F2_0 = 6'b010000, F1_5 = 6'b001110;
  localparam logic [IW-1:0] F0_5 = 6'b001000, FM2_0 = 6'b110000;

  logic clock = 1'b0;
  logic reset;
  logic [IW-1:0] fma_a, fma_b;
  logic [OW-1:0] fma_acc_in, fma_acc_out;
  logic idle;

  float_mac_arbiter_if #(.NUM_REQ(N), .IN_W(IW), .OUT_W(OW)) bus ();

  float_mac_arbiter #(
    .NUM_REQ(N), .EXP_IN(EI), .FRAC_IN(FI), .EXP_OUT(EO), .FRAC_OUT(FO), .FMA_LATENCY(LAT)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .fma_a(fma_a), .fma_b(fma_b), .fma_acc_in(fma_acc_in), .fma_acc_out(fma_acc_out), .idle(idle)
  );

  always #5 clock = ~clock;

  function automatic real pow2(int n);
    real r = 1.0;
    if (n >= 0) for (int k = 0; k < n; k++) r = r * 2.0;
    else for (int k = 0; k < -n; k++) r = r / 2.0;
    return r;
  endfunction

  function automatic real dec(logic [31:0] bits, int e, int f);
    int bias, ef, fr;
    real mag;
    bias = (1 << (e - 1)) - 1;
    ef = int'((bits >> f) & ((32'd1 << e) - 1));
    fr = int'(bits & ((32'd1 << f) - 1));
    if (ef == 0) mag = real'(fr) / real'(1 << f) * pow2(1 - bias);
    else mag = (1.0 + real'(fr) / real'(1 << f)) * pow2(ef - bias);
    return bits[e + f] ? -mag : mag;
  endfunction

  function automatic logic [OW-1:0] enc_out(real v);
    logic s;
    real m;
    int e, fr, ef;
    s = (v < 0.0);
    m = s ? -v : v;
    if (m == 0.0) return {s, 13'd0};
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0 && e > 1 - BO) begin m = m * 2.0; e--; end
    if (m >= 1.0) begin
      fr = $rtoi((m - 1.0) * 256.0 + 0.5);
      ef = e + BO;
      if (fr >= 256) begin fr = 0; ef++; end
    end else begin
      fr = $rtoi(m * 256.0 + 0.5);
      ef = 0;
      if (fr >= 256) begin fr = 0; ef = 1; end
    end
    if (ef > 30) begin ef = 30; fr = 255; end
    return {s, ef[4:0], fr[7:0]};
  endfunction

  // Behavioural FMA: result visible LAT cycles after its inputs are registered.
  logic [OW-1:0] fp0, fp1;
  always @(posedge clock) begin
    fp0 <= enc_out(dec(32'(fma_a), EI, FI) * dec(32'(fma_b), EI, FI) + dec(32'(fma_acc_in), EO, FO));
    fp1 <= fp0;
  end
  assign fma_acc_out = fp1;

  typedef struct { logic [IW-1:0] a; logic [IW-1:0] b; bit last; } elem_t;
  elem_t q[N][$];
  logic [OW-1:0] exp_q[N][$];
  logic [OW-1:0] ref_acc[N];
  bit ref_first[N];
  logic [OW-1:0] last_res[N];
  int last_issue[N], accept_cyc[N];
  int log_id[$], log_cyc[$];
  bit vmask[N], rr_en[N];
  int cyc, errors, checks;
  bit pend;
  logic [IW-1:0] pend_a, pend_b;
  logic [OW-1:0] pend_acc;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic add(int i, logic [IW-1:0] a, logic [IW-1:0] b, bit last);
    elem_t e;
    e.a = a; e.b = b; e.last = last;
    q[i].push_back(e);
  endtask

  function automatic bit drained();
    for (int i = 0; i < N; i++) if (q[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // One cycle: drive at negedge, sample 1ns later, update the reference model.
  task automatic cycle();
    elem_t e;
    @(negedge clock);
    cyc++;
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i] = (q[i].size() > 0) && vmask[i];
      if (q[i].size() > 0) begin
        bus.req_a[i*IW +: IW] = q[i][0].a;
        bus.req_b[i*IW +: IW] = q[i][0].b;
        bus.req_last[i] = q[i][0].last;
      end else begin
        bus.req_a[i*IW +: IW] = '0;
        bus.req_b[i*IW +: IW] = '0;
        bus.req_last[i] = 1'b0;
      end
      bus.res_ready[i] = rr_en[i];
    end
    #1;
    if (pend) begin
      chk("fma_a", 32'(fma_a), 32'(pend_a));
      chk("fma_b", 32'(fma_b), 32'(pend_b));
      chk("fma_acc_in", 32'(fma_acc_in), 32'(pend_acc));
      pend = 1'b0;
    end
    chk("ready_onehot", 32'($onehot0(bus.req_ready)), 1);
    chk("ready_subset_valid", 32'(bus.req_ready & ~bus.req_valid), 0);
    for (int i = 0; i < N; i++) begin
      if (bus.req_valid[i] && bus.req_ready[i]) begin
        chk("issue_spacing", 32'(cyc - last_issue[i] >= 2 + LAT), 1);
        chk("issue_while_result_held", exp_q[i].size(), 0);
        e = q[i].pop_front();
        pend = 1'b1;
        pend_a = e.a;
        pend_b = e.b;
        pend_acc = ref_first[i] ? '0 : ref_acc[i];
        ref_acc[i] = enc_out(dec(32'(e.a), EI, FI) * dec(32'(e.b), EI, FI) + (ref_first[i] ? 0.0 : dec(32'(ref_acc[i]), EO, FO)));
        ref_first[i] = e.last;
        if (e.last) exp_q[i].push_back(ref_acc[i]);
        last_issue[i] = cyc;
        log_id.push_back(i);
        log_cyc.push_back(cyc);
      end
      if (bus.res_valid[i]) begin
        if (exp_q[i].size() == 0) chk("spurious_res_valid", 32'(bus.res_valid[i]), 0);
        else if (bus.res_ready[i]) begin
          chk("res_data", 32'(bus.res_data[i*OW +: OW]), 32'(exp_q[i][0]));
          last_res[i] = bus.res_data[i*OW +: OW];
          void'(exp_q[i].pop_front());
          accept_cyc[i] = cyc;
        end
      end
    end
  endtask

  task automatic run_drain(int budget, string tag);
    int n = 0;
    while (!drained() && n < budget) begin cycle(); n++; end
    chk({tag, "_drain"}, 32'(drained()), 1);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.req_last = '0; bus.res_ready = '0;
    for (int i = 0; i < N; i++) begin
      q[i].delete(); exp_q[i].delete();
      ref_first[i] = 1'b1; ref_acc[i] = '0;
      last_issue[i] = -100; accept_cyc[i] = -100;
      vmask[i] = 1'b1; rr_en[i] = 1'b1;
    end
    log_id.delete(); log_cyc.delete();
    pend = 1'b0;
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_res_valid", 32'(bus.res_valid), 0);
    chk("rst_fma_a", 32'(fma_a), 0);
    chk("rst_fma_b", 32'(fma_b), 0);
    chk("rst_fma_acc_in", 32'(fma_acc_in), 0);
    chk("rst_idle", 32'(idle), 1);
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, rdy2, others, d;
    errors = 0; checks = 0; cyc = 0;
    reset = 1'b1;

    // Single requester two-element stream, then a fresh stream from +0.0.
    do_reset();
    add(0, F1_0, F2_0, 1'b0);
    add(0, F1_5, F2_0, 1'b1);
    run_drain(60, "t1");
    chk("t1_issues", log_id.size(), 2);
    if (log_cyc.size() >= 2) chk("t1_ready_spacing", 32'(log_cyc[1] - log_cyc[0]), 4);
    chk("t1_sum", 32'(last_res[0]), 32'(enc_out(5.0)));
    add(0, F2_0, F2_0, 1'b1);
    run_drain(40, "t1b");
    chk("t1_next_sum", 32'(last_res[0]), 32'(enc_out(4.0)));

    // Four requesters saturating the FMA.
    do_reset();
    for (int i = 0; i < N; i++) for (int k = 0; k < 3; k++) add(i, F1_0, F1_0, k == 2);
    run_drain(100, "t2");
    chk("t2_issues", log_id.size(), 12);
    for (int k = 0; k < 12; k++) if (k < log_id.size()) begin
      chk("t2_grant_order", log_id[k], k % 4);
      chk("t2_back_to_back", 32'(log_cyc[k] - log_cyc[0]), k);
    end
    for (int i = 0; i < N; i++) chk("t2_sum", 32'(last_res[i]), 32'(enc_out(3.0)));

    // Result backpressure on requester 2.
    do_reset();
    rr_en[2] = 1'b0;
    add(2, F1_5, F1_0, 1'b0); add(2, F2_0, F0_5, 1'b1); add(2, F1_0, F1_5, 1'b1);
    for (int k = 0; k < 8; k++) begin
      add(0, F1_0, F0_5, k == 7); add(1, F0_5, F0_5, k == 7); add(3, F1_5, F1_5, k == 7);
    end
    n = 0;
    while (!bus.res_valid[2] && n < 100) begin cycle(); n++; end
    chk("t3_res2_seen", 32'(bus.res_valid[2]), 1);
    rdy2 = 0; others = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      rdy2 += int'(bus.req_ready[2]);
      others += int'(|(bus.req_ready & 4'b1011));
    end
    chk("t3_blocked", rdy2, 0);
    chk("t3_others_issue", 32'(others > 0), 1);
    rr_en[2] = 1'b1;
    cycle();
    chk("t3_accepted", accept_cyc[2], cyc);
    n = 0;
    while (last_issue[2] <= accept_cyc[2] && n < 8) begin cycle(); n++; end
    d = last_issue[2] - accept_cyc[2];
    chk("t3_resume_delay", 32'(d >= 1 && d <= 4), 1);
    run_drain(200, "t3");

    // Single-element stream: a*b + 0.
    do_reset();
    add(3, FM2_0, F0_5, 1'b1);
    run_drain(40, "t4");
    chk("t4_sum", 32'(last_res[3]), 32'(enc_out(-1.0)));

    // Reset with three tags in flight.
    do_reset();
    add(0, F1_0, F2_0, 1'b1); add(1, F1_0, F2_0, 1'b1); add(2, F1_0, F2_0, 1'b1);
    repeat (3) cycle();
    chk("t5_issued", log_id.size(), 3);
    do_reset();
    others = 0;
    for (int k = 0; k < 12; k++) begin cycle(); others += int'(|bus.res_valid); end
    chk("t5_no_writeback", others, 0);
    chk("t5_idle", 32'(idle), 1);
    add(0, F1_5, F1_5, 1'b1);
    run_drain(40, "t5");
    chk("t5_sum", 32'(last_res[0]), 32'(enc_out(2.25)));

    // Random streams on requesters 1 and 3 with toggling valid and ready.
    do_reset();
    for (int s = 0; s < 4; s++) begin
      int len1, len3;
      len1 = int'($urandom_range(1, 4));
      len3 = int'($urandom_range(1, 4));
      for (int k = 0; k < len1; k++) add(1, IW'($urandom), IW'($urandom), k == len1 - 1);
      for (int k = 0; k < len3; k++) add(3, IW'($urandom), IW'($urandom), k == len3 - 1);
    end
    n = 0;
    while (!drained() && n < 800) begin
      vmask[1] = $urandom_range(0, 1) == 1;
      vmask[3] = $urandom_range(0, 1) == 1;
      rr_en[1] = $urandom_range(0, 3) != 0;
      rr_en[3] = $urandom_range(0, 3) != 0;
      cycle();
      n++;
    end
    chk("t6_drain", 32'(drained()), 1);
    repeat (2) cycle();
    chk("t6_idle", 32'(idle), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
